// File: rtl/hilo_seq_ctrl.sv
// Timing and sequencing controller for the multi-cycle HI/LO mult/div unit.
// Optional feature: define HILO_CANCEL_EN to let a CP0 request abort an in-flight op.
module hilo_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       e_valid,
  input  logic [3:0] e_type,
  input  logic       d_hilo,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_commit,
  output logic       hi_we,
  output logic       lo_we,
  output logic       hilo_busy,
  output logic       stall,
  output logic       err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             is_md, is_hilo, cancel;

  assign is_md   = e_type inside {[4'd1:4'd4]};
  assign is_hilo = e_type inside {[4'd1:4'd8]};

`ifdef HILO_CANCEL_EN
  assign cancel = req;
`else
  assign cancel = 1'b0;
`endif

  // NOTE: every combinational output and next-state gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    md_start  = 1'b0;
    md_op     = 2'd0;
    md_commit = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (e_valid && !req) begin
            md_start = is_md;
            hi_we    = (e_type == 4'd7);
            lo_we    = (e_type == 4'd8);
          end
          if (md_start) begin
            md_op   = 2'(e_type - 4'd1);
            cnt_d   = (e_type <= 4'd2) ? MULT_LOAD : DIV_LOAD;
            state_d = RUN;
          end
        end
        RUN: begin
          // Any HI/LO op reaching E here slipped past the stall; flag and drop it.
          if (e_valid && is_hilo) err_d = 1'b1;
          if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            md_commit = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // The commit cycle already releases the stall so a dependent mf lands at t+N+1.
    hilo_busy = reset & (md_start | ((state_q == RUN) & ~md_commit));
    stall     = d_hilo & hilo_busy;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule
